// File: rtl/cci_mpf_csrs_pkg.sv
// Shared MPF CSR definitions: event-counter control commands and the event
// index map used by the CSR manager when wiring shim pulses into the counter bank.
package cci_mpf_csrs_pkg;

    typedef enum logic [1:0] {
        EVT_SET_ENABLE     = 2'd0,
        EVT_CLEAR          = 2'd1,
        EVT_SNAPSHOT       = 2'd2,
        EVT_SNAPSHOT_CLEAR = 2'd3
    } t_cci_mpf_evt_cmd;

    localparam int EVT_VTP_4KB_HIT    = 0;
    localparam int EVT_VTP_4KB_MISS   = 1;
    localparam int EVT_VTP_2MB_HIT    = 2;
    localparam int EVT_VTP_2MB_MISS   = 3;
    localparam int EVT_VTP_PT_WALK    = 4;
    localparam int EVT_WRO_CONFLICT   = 5;
    localparam int EVT_VC_MAP_REMAP   = 6;
    localparam int EVT_PWRITE_PARTIAL = 7;
    localparam int EVT_NUM_DEFINED    = 8;

    function automatic logic cmd_clears(input t_cci_mpf_evt_cmd cmd);
        return (cmd == EVT_CLEAR) || (cmd == EVT_SNAPSHOT_CLEAR);
    endfunction

    function automatic logic cmd_snaps(input t_cci_mpf_evt_cmd cmd);
        return (cmd == EVT_SNAPSHOT) || (cmd == EVT_SNAPSHOT_CLEAR);
    endfunction

endpackage

// File: rtl/cci_mpf_event_counter_slice.sv
// One event counter with sticky overflow and a snapshot copy of both.
// Clear wins over a same-cycle increment; snapshot captures the pre-update value.
module cci_mpf_event_counter_slice #(
    parameter int CNT_WIDTH = 48,
    parameter bit SATURATE  = 1'b1
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 inc,
    input  logic                 clr,
    input  logic                 snap,
    output logic [CNT_WIDTH-1:0] cnt,
    output logic                 ovf,
    output logic                 ovf_next,
    output logic [CNT_WIDTH-1:0] snap_cnt,
    output logic                 snap_ovf
);

    logic [CNT_WIDTH-1:0] cnt_next;

    always_comb begin
        // NOTE: defaults first so every path assigns both outputs; no latch can form.
        cnt_next = cnt;
        ovf_next = ovf;
        if (clr) begin
            cnt_next = '0;
            ovf_next = 1'b0;
        end else if (inc) begin
            if (&cnt) begin
                cnt_next = SATURATE ? cnt : '0;
                ovf_next = 1'b1;
            end else begin
                cnt_next = cnt + CNT_WIDTH'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt      <= '0;
            ovf      <= 1'b0;
            // NOTE: the snapshot bank is reset too, so a never-snapped counter reads 0.
            snap_cnt <= '0;
            snap_ovf <= 1'b0;
        end else begin
            // NOTE: non-blocking, so snap_cnt below sees cnt from before this edge.
            cnt <= cnt_next;
            ovf <= ovf_next;
            if (snap) begin
                snap_cnt <= cnt;
                snap_ovf <= ovf;
            end
        end
    end

endmodule

// File: rtl/cci_mpf_event_counter_bank.sv
// Bank of event counters for MPF shims: registered event input, global enable,
// clear/snapshot commands and a registered read port over live or snapshot values.
module cci_mpf_event_counter_bank
    import cci_mpf_csrs_pkg::*;
#(
    parameter int NUM_EVENTS      = 16,
    parameter int CNT_WIDTH       = 48,
    parameter bit SATURATE        = 1'b1,
    parameter bit ENABLE_AT_RESET = 1'b1,
    parameter int IDX_W           = (NUM_EVENTS > 1) ? $clog2(NUM_EVENTS) : 1
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic [NUM_EVENTS-1:0] evt_in,
    input  logic                  ctrl_valid,
    input  logic [1:0]            ctrl_cmd,
    input  logic                  ctrl_enable,
    input  logic                  rd_req,
    input  logic [IDX_W-1:0]      rd_idx,
    input  logic                  rd_live,
    output logic                  rd_rsp_valid,
    output logic [CNT_WIDTH-1:0]  rd_rsp_data,
    output logic                  rd_rsp_ovf,
    output logic                  enabled,
    output logic                  overflow_any
);

    // Read mux spans every encodable index; slots past NUM_EVENTS read as zero.
    localparam int NUM_SLOTS = 1 << IDX_W;

    t_cci_mpf_evt_cmd      cmd;
    logic                  do_clr;
    logic                  do_snap;
    logic                  do_set_en;
    logic [NUM_EVENTS-1:0] evt_q;
    logic [NUM_EVENTS-1:0] ovf_next_vec;
    logic [CNT_WIDTH-1:0]  cnt_arr  [NUM_SLOTS];
    logic [CNT_WIDTH-1:0]  snap_arr [NUM_SLOTS];
    logic [NUM_SLOTS-1:0]  ovf_vec;
    logic [NUM_SLOTS-1:0]  snap_ovf_vec;

    assign cmd       = t_cci_mpf_evt_cmd'(ctrl_cmd);
    assign do_clr    = ctrl_valid && cmd_clears(cmd);
    assign do_snap   = ctrl_valid && cmd_snaps(cmd);
    assign do_set_en = ctrl_valid && (cmd == EVT_SET_ENABLE);

    for (genvar i = 0; i < NUM_SLOTS; i++) begin : g_slot
        if (i < NUM_EVENTS) begin : g_cnt
            cci_mpf_event_counter_slice #(
                .CNT_WIDTH (CNT_WIDTH),
                .SATURATE  (SATURATE)
            ) u_slice (
                .clk      (clk),
                .reset_n  (reset_n),
                .inc      (enabled && evt_q[i]),
                .clr      (do_clr),
                .snap     (do_snap),
                .cnt      (cnt_arr[i]),
                .ovf      (ovf_vec[i]),
                .ovf_next (ovf_next_vec[i]),
                .snap_cnt (snap_arr[i]),
                .snap_ovf (snap_ovf_vec[i])
            );
        end else begin : g_pad
            assign cnt_arr[i]      = '0;
            assign snap_arr[i]     = '0;
            assign ovf_vec[i]      = 1'b0;
            assign snap_ovf_vec[i] = 1'b0;
        end
    end

    // Enable is sampled by the slices before this edge, so a SET_ENABLE only
    // gates evt_q from the following cycle.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            evt_q        <= '0;
            enabled      <= ENABLE_AT_RESET;
            overflow_any <= 1'b0;
        end else begin
            evt_q        <= evt_in;
            overflow_any <= |ovf_next_vec;
            if (do_set_en) begin
                enabled <= ctrl_enable;
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rd_rsp_valid <= 1'b0;
            rd_rsp_data  <= '0;
            rd_rsp_ovf   <= 1'b0;
        end else begin
            rd_rsp_valid <= rd_req;
            if (rd_req) begin
                rd_rsp_data <= rd_live ? cnt_arr[rd_idx] : snap_arr[rd_idx];
                rd_rsp_ovf  <= rd_live ? ovf_vec[rd_idx] : snap_ovf_vec[rd_idx];
            end
        end
    end

endmodule

// File: tb/tb_cci_mpf_event_counter_bank.sv
// Scoreboard bench: a saturating and a wrapping 8-bit bank share one stimulus
// stream; expected read responses are queued at issue and checked by monitors.
module tb_cci_mpf_event_counter_bank;

    localparam int NE = 12;
    localparam int CW = 8;
    localparam int IW = 4;

    logic          clk = 1'b0;
    logic          reset_n;
    logic [NE-1:0] evt_in;
    logic          ctrl_valid;
    logic [1:0]    ctrl_cmd;
    logic          ctrl_enable;
    logic          rd_req;
    logic [IW-1:0] rd_idx;
    logic          rd_live;

    logic          vld_s, ovf_s, en_s, oa_s;
    logic [CW-1:0] data_s;
    logic          vld_w, ovf_w, en_w, oa_w;
    logic [CW-1:0] data_w;

    typedef struct {
        logic [CW-1:0] data;
        logic          ovf;
        int            tag;
    } exp_t;

    exp_t q_s[$];
    exp_t q_w[$];
    int   n_checks = 0;
    int   n_fail   = 0;
    int   rd_tag   = 0;

    always #5 clk = ~clk;

    cci_mpf_event_counter_bank #(
        .NUM_EVENTS(NE), .CNT_WIDTH(CW), .SATURATE(1'b1), .ENABLE_AT_RESET(1'b1), .IDX_W(IW)
    ) dut_sat (
        .clk(clk), .reset_n(reset_n), .evt_in(evt_in), .ctrl_valid(ctrl_valid),
        .ctrl_cmd(ctrl_cmd), .ctrl_enable(ctrl_enable), .rd_req(rd_req), .rd_idx(rd_idx),
        .rd_live(rd_live), .rd_rsp_valid(vld_s), .rd_rsp_data(data_s), .rd_rsp_ovf(ovf_s),
        .enabled(en_s), .overflow_any(oa_s)
    );

    cci_mpf_event_counter_bank #(
        .NUM_EVENTS(NE), .CNT_WIDTH(CW), .SATURATE(1'b0), .ENABLE_AT_RESET(1'b1), .IDX_W(IW)
    ) dut_wrap (
        .clk(clk), .reset_n(reset_n), .evt_in(evt_in), .ctrl_valid(ctrl_valid),
        .ctrl_cmd(ctrl_cmd), .ctrl_enable(ctrl_enable), .rd_req(rd_req), .rd_idx(rd_idx),
        .rd_live(rd_live), .rd_rsp_valid(vld_w), .rd_rsp_data(data_w), .rd_rsp_ovf(ovf_w),
        .enabled(en_w), .overflow_any(oa_w)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Monitors: pop one expectation per presented response.
    always @(negedge clk) begin
        exp_t e;
        if (vld_s === 1'b1) begin
            if (q_s.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL sat_unexpected_rsp: got data %0h expected no response", data_s);
            end else begin
                e = q_s.pop_front();
                check($sformatf("sat_rd%0d_data", e.tag), 64'(data_s), 64'(e.data));
                check($sformatf("sat_rd%0d_ovf", e.tag), 64'(ovf_s), 64'(e.ovf));
            end
        end
    end

    always @(negedge clk) begin
        exp_t e;
        if (vld_w === 1'b1) begin
            if (q_w.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL wrap_unexpected_rsp: got data %0h expected no response", data_w);
            end else begin
                e = q_w.pop_front();
                check($sformatf("wrap_rd%0d_data", e.tag), 64'(data_w), 64'(e.data));
                check($sformatf("wrap_rd%0d_ovf", e.tag), 64'(ovf_w), 64'(e.ovf));
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse(input logic [NE-1:0] mask, input int n);
        for (int i = 0; i < n; i++) begin
            evt_in = mask;
            tick();
        end
        evt_in = '0;
    endtask

    task automatic ctrl(input logic [1:0] c, input logic en);
        ctrl_valid  = 1'b1;
        ctrl_cmd    = c;
        ctrl_enable = en;
        tick();
        ctrl_valid  = 1'b0;
    endtask

    // Issues one read; rd_req stays high so consecutive calls are back-to-back.
    task automatic rd(input int idx, input logic live,
                      input logic [CW-1:0] ds, input logic os,
                      input logic [CW-1:0] dw, input logic ow);
        rd_req  = 1'b1;
        rd_idx  = IW'(idx);
        rd_live = live;
        q_s.push_back(exp_t'{ds, os, rd_tag});
        q_w.push_back(exp_t'{dw, ow, rd_tag});
        rd_tag++;
        tick();
    endtask

    task automatic rd_end();
        rd_req = 1'b0;
        tick();
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1);
    end

    initial begin
        reset_n     = 1'b0;
        evt_in      = '0;
        ctrl_valid  = 1'b0;
        ctrl_cmd    = 2'd0;
        ctrl_enable = 1'b0;
        rd_req      = 1'b0;
        rd_idx      = '0;
        rd_live     = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("reset_valid_s", 64'(vld_s), 64'd0);
        check("reset_enabled_s", 64'(en_s), 64'd1);
        check("reset_ovf_any_w", 64'(oa_w), 64'd0);
        reset_n = 1'b1;
        tick();

        rd(3, 1'b1, 8'd0, 1'b0, 8'd0, 1'b0);
        rd(3, 1'b0, 8'd0, 1'b0, 8'd0, 1'b0);
        rd_end();

        // Five pulses on event 3.
        pulse(12'h008, 5);
        tick();
        rd(3, 1'b1, 8'd5, 1'b0, 8'd5, 1'b0);
        rd(2, 1'b1, 8'd0, 1'b0, 8'd0, 1'b0);
        rd_end();

        // 300 pulses on event 0: saturate at 255 vs wrap to 44.
        pulse(12'h001, 300);
        tick();
        check("sat_ovf_any_set", 64'(oa_s), 64'd1);
        check("wrap_ovf_any_set", 64'(oa_w), 64'd1);
        rd(0, 1'b1, 8'd255, 1'b1, 8'd44, 1'b1);
        rd_end();

        // Snapshot then clear: live bank zeroes, snapshot bank survives.
        ctrl(2'd2, 1'b0);
        ctrl(2'd1, 1'b0);
        check("sat_ovf_any_cleared", 64'(oa_s), 64'd0);
        check("wrap_ovf_any_cleared", 64'(oa_w), 64'd0);
        rd(0, 1'b1, 8'd0, 1'b0, 8'd0, 1'b0);
        rd(0, 1'b0, 8'd255, 1'b1, 8'd44, 1'b1);
        rd(3, 1'b0, 8'd5, 1'b0, 8'd5, 1'b0);
        rd(3, 1'b1, 8'd0, 1'b0, 8'd0, 1'b0);
        rd_end();

        // Event 1 at 10, increment lands on SNAPSHOT_AND_CLEAR: dropped.
        pulse(12'h002, 10);
        tick();
        pulse(12'h002, 1);
        ctrl(2'd3, 1'b0);
        rd(1, 1'b0, 8'd10, 1'b0, 8'd10, 1'b0);
        rd(1, 1'b1, 8'd0, 1'b0, 8'd0, 1'b0);
        rd_end();

        // Event 1 at 10, increment lands on SNAPSHOT: live advances to 11.
        pulse(12'h002, 10);
        tick();
        pulse(12'h002, 1);
        ctrl(2'd2, 1'b0);
        rd(1, 1'b0, 8'd10, 1'b0, 8'd10, 1'b0);
        rd(1, 1'b1, 8'd11, 1'b0, 8'd11, 1'b0);
        rd_end();

        // Disable gates pulses; re-enable resumes counting.
        ctrl(2'd0, 1'b0);
        check("sat_enabled_off", 64'(en_s), 64'd0);
        check("wrap_enabled_off", 64'(en_w), 64'd0);
        pulse(12'h002, 4);
        tick();
        rd(1, 1'b1, 8'd11, 1'b0, 8'd11, 1'b0);
        rd_end();
        ctrl(2'd0, 1'b1);
        check("sat_enabled_on", 64'(en_s), 64'd1);
        pulse(12'h002, 2);
        tick();
        rd(1, 1'b1, 8'd13, 1'b0, 8'd13, 1'b0);

        // Out-of-range indices still respond, with zeros.
        rd(NE, 1'b1, 8'd0, 1'b0, 8'd0, 1'b0);
        rd(15, 1'b0, 8'd0, 1'b0, 8'd0, 1'b0);
        rd_end();
        tick();

        // Reset while a read response is in flight.
        rd_req  = 1'b1;
        rd_idx  = IW'(1);
        rd_live = 1'b1;
        @(posedge clk);
        #1;
        reset_n = 1'b0;
        rd_req  = 1'b0;
        @(negedge clk);
        check("sat_rsp_suppressed", 64'(vld_s), 64'd0);
        check("wrap_rsp_suppressed", 64'(vld_w), 64'd0);
        tick();
        tick();
        check("sat_enabled_after_reset", 64'(en_s), 64'd1);
        check("wrap_valid_in_reset", 64'(vld_w), 64'd0);
        reset_n = 1'b1;
        tick();
        rd(1, 1'b1, 8'd0, 1'b0, 8'd0, 1'b0);
        rd(1, 1'b0, 8'd0, 1'b0, 8'd0, 1'b0);
        rd(3, 1'b0, 8'd0, 1'b0, 8'd0, 1'b0);
        rd_end();

        for (int i = 0; i < 10 && (q_s.size() + q_w.size()) != 0; i++) begin
            tick();
        end
        check("scoreboard_drained", 64'(q_s.size() + q_w.size()), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/cci_mpf_event_counter_bank.md
# cci_mpf_event_counter_bank

Parametrised bank of event counters that sums single-cycle event pulses from MPF shims (VTP, WRO, VC map, PWRITE, etc.) into per-event counters for CSR readback. It sits behind the MPF CSR manager, replacing ad-hoc fixed-width counters. It adds global enable, clear, coherent snapshot, a selectable saturate/wrap mode and sticky per-counter overflow flags.

## Interface
- NUM_EVENTS, 16: number of event inputs/counters (1..64)
- CNT_WIDTH, 48: counter width in bits (8..64)
- SATURATE, 1: 1 = counters hold at max; 0 = counters wrap to 0
- ENABLE_AT_RESET, 1: value of `enabled` after reset
- IDX_W, $clog2(NUM_EVENTS) (minimum 1): read index width
- clk  in  1  clock
- reset_n  in  1  asynchronous, active-low reset
- evt_in  in  NUM_EVENTS  event pulses; bit i high = one event on counter i this cycle
- ctrl_valid  in  1  control command strobe
- ctrl_cmd  in  2  0 SET_ENABLE, 1 CLEAR, 2 SNAPSHOT, 3 SNAPSHOT_AND_CLEAR
- ctrl_enable  in  1  new enable value; used only with SET_ENABLE
- rd_req  in  1  read request
- rd_idx  in  IDX_W  counter index to read
- rd_live  in  1  1 = read live counter; 0 = read snapshot
- rd_rsp_valid  out  1  read response valid
- rd_rsp_data  out  CNT_WIDTH  counter value
- rd_rsp_ovf  out  1  overflow flag paired with the returned value
- enabled  out  1  current global enable
- overflow_any  out  1  OR of all live overflow flags

## Operation
- Stage 1: `evt_in` registered into `evt_q`, unconditionally.
- Stage 2: for each i, if `enabled` and `evt_q[i]`, counter i increments by 1.
- Counter at all-ones receiving an increment:
  - SATURATE=1: holds at 2^CNT_WIDTH-1.
  - SATURATE=0: wraps to 0.
  - In both modes, sticky ovf[i] sets.
- SET_ENABLE: `enabled` <= `ctrl_enable`. Events already in `evt_q` are gated by the new value from the next cycle onward.
- CLEAR: all counters and ovf <= 0. Any `evt_q` increment in the same cycle is dropped. Snapshot bank is untouched.
- SNAPSHOT: snap[i] <= cnt[i] and snap_ovf[i] <= ovf[i]. The captured value excludes the same-cycle increment; that increment still lands in the live counter.
- SNAPSHOT_AND_CLEAR: snapshot captures as for SNAPSHOT, then live counters and ovf clear. The same-cycle increment is dropped.
- Reads:
  - `rd_req` samples the selected bank at the clock edge and returns pre-update register values.
  - `rd_idx` >= NUM_EVENTS returns data 0, ovf 0, with rd_rsp_valid still asserted.
- Reads and control commands are accepted every cycle. There is no backpressure.

## Timing
- Reset (async assert, sync deassert handled upstream):
  - cnt, snap, ovf, snap_ovf, evt_q <= 0; rd_rsp_valid <= 0; rd_rsp_data <= 0; rd_rsp_ovf <= 0.
  - enabled <= ENABLE_AT_RESET; overflow_any <= 0.
- Event latency: pulse on `evt_in` in cycle N is visible to a read issued in cycle N+2. Response arrives in N+3.
- Read latency: rd_rsp_valid is high exactly 1 cycle after rd_req. Back-to-back reads give back-to-back responses.
- Control takes effect at the edge ending the ctrl_valid cycle. A read in cycle N+1 observes it.
- Reset mid-operation: all state is lost immediately. An in-flight read response is suppressed (rd_rsp_valid low).
- overflow_any is registered and updates in the same cycle as ovf.

## Structure
- The shared package (cci_mpf_csrs_pkg) holds:
  - enum t_cci_mpf_evt_cmd (EVT_SET_ENABLE, EVT_CLEAR, EVT_SNAPSHOT, EVT_SNAPSHOT_CLEAR).
  - the event index constants used by the CSR manager, e.g. EVT_VTP_4KB_HIT=0.
- Sub-module cci_mpf_event_counter_slice contains:
  - one counter plus ovf, snap and snap_ovf.
  - inputs: inc, clr, snap, SATURATE parameter.
  - instantiated NUM_EVENTS times via generate.
- Top level contains the evt_q register, enable register, command decode and registered read mux.

## Test plan
- Reset, ENABLE_AT_RESET=1 -> enabled=1, all reads return 0/ovf 0. Pulse evt_in[3] 5 cycles -> live read idx 3 returns 5, idx 2 returns 0.
- CNT_WIDTH=8, SATURATE=1, 300 pulses on evt 0 -> read 255, ovf=1, overflow_any=1. Same with SATURATE=0 -> read 44, ovf=1.
- Counter at 10, evt pulse timed so its increment lands on a SNAPSHOT_AND_CLEAR cycle -> snapshot read 10, live read 0.
- Counter at 10, SNAPSHOT issued on the cycle an increment lands -> snapshot 10, live 11.
- SET_ENABLE 0, then 4 pulses -> count unchanged. SET_ENABLE 1, then 2 pulses -> count +2.
- rd_idx=NUM_EVENTS -> rd_rsp_valid=1, data 0. reset_n pulled low while rd_req is outstanding -> rd_rsp_valid stays 0 and all counters read 0 after reset.
